// File: rtl/me_block_sequencer.sv
// Block/frame sequencer for the motion-estimation pipeline: load -> run -> writeback per block.
// Optional watchdog on the handshake waits: define MEMC_SEQ_TIMEOUT_EN.
module me_block_sequencer #(
   parameter int NUM_BLOCKS  = 48,
   parameter int FIRST_FRAME = 1,
   parameter int LAST_FRAME  = 9
`ifdef MEMC_SEQ_TIMEOUT_EN
   ,
   parameter int TO_CYCLES   = 1024
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       load_req,
   input  logic       load_ack,
   output logic       me_start,
   input  logic       me_done,
   output logic       wb_req,
   input  logic       wb_ack,
   output logic [3:0] frame_id,
   output logic [5:0] block_id,
   output logic       block_done,
   output logic       frame_done,
   output logic       frame_inc,
   output logic       busy,
   output logic       all_done
`ifdef MEMC_SEQ_TIMEOUT_EN
   ,
   output logic       timeout_err
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_WAIT,
      S_WB,
      S_NEXT
   } state_t;

   localparam logic [5:0] LAST_BLK = 6'(NUM_BLOCKS - 1);
   localparam logic [3:0] FIRST_F  = 4'(FIRST_FRAME);
   localparam logic [3:0] LAST_F   = 4'(LAST_FRAME);

   state_t     state_q, state_d;
   logic       load_req_q, load_req_d;
   logic       me_start_q, me_start_d;
   logic       wb_req_q, wb_req_d;
   logic [3:0] frame_q, frame_d;
   logic [5:0] block_q, block_d;
   logic       block_done_q, block_done_d;
   logic       frame_done_q, frame_done_d;
   logic       frame_inc_q, frame_inc_d;
   logic       busy_q, busy_d;
   logic       all_done_q, all_done_d;
   logic       done_lat_q, done_lat_d;

`ifdef MEMC_SEQ_TIMEOUT_EN
   localparam logic [15:0] TO_LIM = 16'(TO_CYCLES - 1);

   logic        to_err_q, to_err_d;
   logic [15:0] cnt_q, cnt_d;
   state_t      resume_q, resume_d;
   logic        waiting;
`endif

   always_comb begin
      state_d      = state_q;
      load_req_d   = load_req_q;
      me_start_d   = 1'b0;
      wb_req_d     = wb_req_q;
      frame_d      = frame_q;
      block_d      = block_q;
      block_done_d = 1'b0;
      frame_done_d = 1'b0;
      frame_inc_d  = 1'b0;
      all_done_d   = 1'b0;
      done_lat_d   = done_lat_q;
`ifdef MEMC_SEQ_TIMEOUT_EN
      to_err_d     = to_err_q;
      resume_d     = resume_q;
      waiting      = 1'b0;
      cnt_d        = cnt_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_LOAD;
               load_req_d = 1'b1;
`ifdef MEMC_SEQ_TIMEOUT_EN
               // Pick up the interrupted handshake where it stalled.
               if (to_err_q) begin
                  state_d    = resume_q;
                  load_req_d = (resume_q == S_LOAD);
                  wb_req_d   = (resume_q == S_WB);
                  to_err_d   = 1'b0;
               end
`endif
            end
         end
         S_LOAD: begin
            if (load_ack) begin
               load_req_d = 1'b0;
               me_start_d = 1'b1;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            done_lat_d = me_done;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (me_done || done_lat_q) begin
               done_lat_d = 1'b0;
               wb_req_d   = 1'b1;
               state_d    = S_WB;
            end
         end
         S_WB: begin
            if (wb_ack) begin
               wb_req_d     = 1'b0;
               block_done_d = 1'b1;
               frame_done_d = (block_q == LAST_BLK);
               state_d      = S_NEXT;
            end
         end
         S_NEXT: begin
            if (block_q != LAST_BLK) begin
               block_d    = block_q + 6'd1;
               load_req_d = 1'b1;
               state_d    = S_LOAD;
            end else begin
               block_d = 6'd0;
               if (frame_q != LAST_F) begin
                  frame_d     = frame_q + 4'd1;
                  frame_inc_d = 1'b1;
                  load_req_d  = 1'b1;
                  state_d     = S_LOAD;
               end else begin
                  frame_d    = FIRST_F;
                  all_done_d = 1'b1;
                  state_d    = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef MEMC_SEQ_TIMEOUT_EN
      waiting = (state_q == S_LOAD) || (state_q == S_WAIT) ||
                (state_q == S_WB);
      if (waiting && (cnt_q == TO_LIM) && (state_d == state_q)) begin
         state_d    = S_IDLE;
         load_req_d = 1'b0;
         wb_req_d   = 1'b0;
         done_lat_d = 1'b0;
         to_err_d   = 1'b1;
         resume_d   = state_q;
      end
      if (state_d != state_q) begin
         cnt_d = 16'd0;
      end else if (waiting) begin
         cnt_d = cnt_q + 16'd1;
      end
`endif

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         load_req_q   <= 1'b0;
         me_start_q   <= 1'b0;
         wb_req_q     <= 1'b0;
         frame_q      <= FIRST_F;
         block_q      <= 6'd0;
         block_done_q <= 1'b0;
         frame_done_q <= 1'b0;
         frame_inc_q  <= 1'b0;
         busy_q       <= 1'b0;
         all_done_q   <= 1'b0;
         done_lat_q   <= 1'b0;
`ifdef MEMC_SEQ_TIMEOUT_EN
         to_err_q     <= 1'b0;
         cnt_q        <= 16'd0;
         resume_q     <= S_LOAD;
`endif
      end else begin
         state_q      <= state_d;
         load_req_q   <= load_req_d;
         me_start_q   <= me_start_d;
         wb_req_q     <= wb_req_d;
         frame_q      <= frame_d;
         block_q      <= block_d;
         block_done_q <= block_done_d;
         frame_done_q <= frame_done_d;
         frame_inc_q  <= frame_inc_d;
         busy_q       <= busy_d;
         all_done_q   <= all_done_d;
         done_lat_q   <= done_lat_d;
`ifdef MEMC_SEQ_TIMEOUT_EN
         to_err_q     <= to_err_d;
         cnt_q        <= cnt_d;
         resume_q     <= resume_d;
`endif
      end
   end

   assign load_req   = load_req_q;
   assign me_start   = me_start_q;
   assign wb_req     = wb_req_q;
   assign frame_id   = frame_q;
   assign block_id   = block_q;
   assign block_done = block_done_q;
   assign frame_done = frame_done_q;
   assign frame_inc  = frame_inc_q;
   assign busy       = busy_q;
   assign all_done   = all_done_q;
`ifdef MEMC_SEQ_TIMEOUT_EN
   assign timeout_err = to_err_q;
`endif

endmodule

// File: tb/tb_me_block_sequencer.sv
// Bench for me_block_sequencer: delay-table vectors, randomized handshakes
// against a frame/block model, reset abort and (optionally) watchdog resume.
module tb_me_block_sequencer;

   localparam int NB = 48;
   localparam int FF = 1;
   localparam int LF = 9;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       load_ack = 1'b0;
   logic       me_done = 1'b0;
   logic       wb_ack = 1'b0;
   logic       load_req, me_start, wb_req;
   logic [3:0] frame_id;
   logic [5:0] block_id;
   logic       block_done, frame_done, frame_inc, busy, all_done;
`ifdef MEMC_SEQ_TIMEOUT_EN
   logic       timeout_err;
`endif

   me_block_sequencer #(
      .NUM_BLOCKS (NB),
      .FIRST_FRAME(FF),
      .LAST_FRAME (LF)
`ifdef MEMC_SEQ_TIMEOUT_EN
      ,
      .TO_CYCLES  (16)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .load_req   (load_req),
      .load_ack   (load_ack),
      .me_start   (me_start),
      .me_done    (me_done),
      .wb_req     (wb_req),
      .wb_ack     (wb_ack),
      .frame_id   (frame_id),
      .block_id   (block_id),
      .block_done (block_done),
      .frame_done (frame_done),
      .frame_inc  (frame_inc),
      .busy       (busy),
      .all_done   (all_done)
`ifdef MEMC_SEQ_TIMEOUT_EN
      ,
      .timeout_err(timeout_err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Responder delays: ack in the Nth cycle of the request (0 = never);
   // me_dly = cycles after the me_start cycle, 0 = in the me_start cycle.
   int ld_dly = 1, me_dly = 1, wb_dly = 1;
   int ld_cnt = 0, wb_cnt = 0, me_cnt = 0;
   bit me_pend = 0;

   bit rand_mode = 0, model_en = 0, have_exp = 0;
   int cyc = 0, n_bd = 0, n_fd = 0, n_fi = 0, n_ad = 0;
   int last_bd = 0, period = 0, fd_cyc = 0;
   int ld_run = 0, wb_run = 0, ld_hold = 0, wb_hold = 0, ms_blk = 0;
   int exp_f = FF, exp_b = 0, exp_per = 0, used_ld = 0, used_wb = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            ld_cnt = 0; wb_cnt = 0; me_pend = 0;
            load_ack = 0; me_done = 0; wb_ack = 0;
         end else begin
            ld_cnt = load_req ? ld_cnt + 1 : 0;
            load_ack = load_req && (ld_cnt == ld_dly);
            wb_cnt = wb_req ? wb_cnt + 1 : 0;
            wb_ack = wb_req && (wb_cnt == wb_dly);
            if (me_start) begin
               me_cnt = 0;
               me_pend = (me_dly != 0);
               me_done = (me_dly == 0);
            end else if (me_pend) begin
               me_cnt++;
               me_done = (me_cnt == me_dly);
               if (me_done) me_pend = 0;
            end else begin
               me_done = 0;
            end
         end

         if (load_req) ld_run++;
         else if (ld_run > 0) begin ld_hold = ld_run; ld_run = 0; end
         if (wb_req) wb_run++;
         else if (wb_run > 0) begin wb_hold = wb_run; wb_run = 0; end
         if (me_start) ms_blk++;

         if (block_done) begin
            n_bd++;
            period = cyc - last_bd;
            last_bd = cyc;
            if (model_en) begin
               chk("blk_frame", int'(frame_id), exp_f);
               chk("blk_id", int'(block_id), exp_b);
               chk("me_start_per_blk", ms_blk, 1);
               chk("frame_done_flag", int'(frame_done), int'(exp_b == NB - 1));
               if (rand_mode && have_exp) begin
                  chk("rand_period", period, exp_per);
                  chk("rand_ld_hold", ld_hold, used_ld);
                  chk("rand_wb_hold", wb_hold, used_wb);
               end
               exp_b++;
               if (exp_b == NB) begin
                  exp_b = 0;
                  exp_f = (exp_f == LF) ? FF : exp_f + 1;
               end
            end
            ms_blk = 0;
            if (rand_mode) begin
               ld_dly = $urandom_range(1, 5);
               me_dly = $urandom_range(0, 4);
               wb_dly = $urandom_range(1, 5);
               used_ld = ld_dly;
               used_wb = wb_dly;
               exp_per = ld_dly + 1 + ((me_dly == 0) ? 1 : me_dly) + wb_dly + 1;
               have_exp = 1;
            end
         end
         if (frame_done) begin n_fd++; fd_cyc = cyc; end
         if (frame_inc) begin
            n_fi++;
            if (model_en) begin
               chk("inc_after_done", cyc - fd_cyc, 1);
               chk("inc_frame", int'(frame_id), exp_f);
            end
         end
         if (all_done) begin
            n_ad++;
            if (model_en) begin
               chk("all_done_frame", int'(frame_id), FF);
               chk("all_done_busy", int'(busy), 0);
               chk("all_done_block", int'(block_id), 0);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_bd(input int n, input int budget);
      int tgt;
      tgt = n_bd + n;
      for (int i = 0; i < budget && n_bd < tgt; i++) step();
      chk("block_done_reached", int'(n_bd >= tgt), 1);
   endtask

   task automatic wait_ad(input int n, input int budget);
      for (int i = 0; i < budget && n_ad < n; i++) step();
      chk("all_done_reached", int'(n_ad >= n), 1);
   endtask

   function automatic int outs();
      return int'({load_req, me_start, wb_req, block_done,
                   frame_done, frame_inc, busy, all_done});
   endfunction

   typedef struct {
      int ld;
      int me;
      int wb;
      int per;
   } vec_t;

   vec_t tbl[6];
   int   base;
   bit   found;

   initial begin
      tbl[0] = '{ld: 1, me: 1, wb: 1, per: 5};
      tbl[1] = '{ld: 7, me: 1, wb: 1, per: 11};
      tbl[2] = '{ld: 1, me: 1, wb: 7, per: 11};
      tbl[3] = '{ld: 1, me: 0, wb: 1, per: 5};
      tbl[4] = '{ld: 3, me: 4, wb: 2, per: 11};
      tbl[5] = '{ld: 2, me: 3, wb: 5, per: 12};

      repeat (3) step();
      chk("rst_outputs", outs(), 0);
      chk("rst_frame", int'(frame_id), FF);
      chk("rst_block", int'(block_id), 0);
      rst_n = 1'b1;
      step();
      chk("idle_no_start", outs(), 0);
      model_en = 1;

      pulse_start();
      chk("load_req_rise", int'(load_req), 1);
      chk("busy_rise", int'(busy), 1);
      wait_bd(1, 50);

      foreach (tbl[i]) begin
         ld_dly = tbl[i].ld;
         me_dly = tbl[i].me;
         wb_dly = tbl[i].wb;
         wait_bd(1, 100);
         chk($sformatf("vec%0d_period", i), period, tbl[i].per);
         chk($sformatf("vec%0d_ld_hold", i), ld_hold, tbl[i].ld);
         chk($sformatf("vec%0d_wb_hold", i), wb_hold, tbl[i].wb);
      end

      ld_dly = 1; me_dly = 1; wb_dly = 1;
      wait_ad(1, 4000);
      chk("run_block_done", n_bd, 432);
      chk("run_frame_done", n_fd, 9);
      chk("run_frame_inc", n_fi, 8);
      chk("run_all_done", n_ad, 1);
      step();
      chk("end_frame", int'(frame_id), FF);
      chk("end_busy", int'(busy), 0);
      chk("end_idle_outs", outs(), 0);

      base = n_bd;
      rand_mode = 1;
      have_exp = 0;
      ld_dly = $urandom_range(1, 5);
      me_dly = $urandom_range(0, 4);
      wb_dly = $urandom_range(1, 5);
      pulse_start();
      wait_ad(2, 9000);
      rand_mode = 0;
      chk("rand_block_count", n_bd - base, 432);
      chk("rand_frame_count", n_fd, 18);

      ld_dly = 1; me_dly = 5; wb_dly = 1;
      step();
      pulse_start();
      found = 0;
      for (int i = 0; i < 3000 && !found; i++) begin
         step();
         found = (frame_id == 4'd3) && (block_id == 6'd20) && me_start;
      end
      chk("reached_f3_b20", int'(found), 1);
      step();
      chk("busy_in_wait", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", outs(), 0);
      chk("abort_frame", int'(frame_id), FF);
      chk("abort_block", int'(block_id), 0);
      step();
      exp_f = FF; exp_b = 0; ms_blk = 0;
      me_dly = 1;
      rst_n = 1'b1;
      step();
      pulse_start();
      chk("restart_load_req", int'(load_req), 1);
      chk("restart_frame", int'(frame_id), FF);
      wait_bd(3, 100);
      rst_n = 1'b0;
      step();
      exp_f = FF; exp_b = 0; ms_blk = 0;
      rst_n = 1'b1;
      step();

`ifdef MEMC_SEQ_TIMEOUT_EN
      wb_dly = 0;
      pulse_start();
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         step();
         found = timeout_err;
      end
      chk("timeout_seen", int'(found), 1);
      chk("timeout_wb_hold", wb_hold, 16);
      chk("timeout_busy", int'(busy), 0);
      chk("timeout_wb_req", int'(wb_req), 0);
      chk("timeout_block", int'(block_id), 0);
      wb_dly = 1;
      pulse_start();
      chk("resume_err_clear", int'(timeout_err), 0);
      chk("resume_wb_req", int'(wb_req), 1);
      wait_bd(1, 20);
      chk("resume_block", int'(block_id), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
